// File: rtl/mem_stream_reader_pkg.sv
// Shared types and default parameters for the memory stream reader.
package mem_stream_reader_pkg;

    localparam int unsigned DefaultAddrW     = 16;
    localparam int unsigned DefaultDataW     = 8;
    localparam int unsigned DefaultLastAddr  = 35000;
    localparam int unsigned DefaultFifoDepth = 4;

    // Read sequencer states: waiting, issuing reads, emptying the buffer.
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a head output taken straight from storage.
// The head is selected by the registered read pointer, so it never depends
// combinationally on push or pop. Push into a full FIFO is accepted only
// together with a pop in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; reset also clears the storage so the
    // head reads as zero after a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Memory stream reader: walks addresses 0..LAST_ADDR on a start pulse, reads
// a one-cycle-latency RAM, buffers words in sync_fifo and streams them out on
// valid/ready. Reads are issued only while buffer space is guaranteed, so a
// stalled consumer never causes a dropped word.
// Optional feature macro: MEM_STREAM_READER_CHECKSUM_EN (16-bit running sum
// of accepted words; checksum is tied to zero when undefined).
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefaultAddrW,
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned LAST_ADDR  = DefaultLastAddr,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inflight_q;
    logic                inflight_last_q;
    logic                start_accept;
    logic                is_last_addr;
    logic                credit_ok;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CntW-1:0]     fifo_count;
    logic [DATA_W:0]     fifo_head;
    logic                pop;

    assign start_accept = (state_q == StIdle) && start;
    assign is_last_addr = (addr_q == ADDR_W'(LAST_ADDR));
    // Words already buffered plus the one possibly on the RAM bus must fit.
    assign credit_ok    = !fifo_full &&
                          (({1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q}) <
                           (CntW + 1)'(FIFO_DEPTH));

    assign mem_addr  = addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_last  = fifo_head[DATA_W];
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q != StIdle) && !done;

    // Next-state, read strobe, address advance and completion pulse.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_rd_en = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_accept) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                mem_rd_en = credit_ok;
                if (credit_ok) begin
                    addr_d = is_last_addr ? '0 : addr_q + ADDR_W'(1);
                    if (is_last_addr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, address and read-in-flight tracking; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inflight_q      <= mem_rd_en;
            inflight_last_q <= mem_rd_en && is_last_addr;
        end
    end

    sync_fifo #(
        .Width (DATA_W + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .wdata ({inflight_last_q, mem_rdata}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Running sum of accepted words; cleared when a new pass begins.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + 16'(out_data);
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a small instance (LAST_ADDR=7) under directed
// and randomized flow control, plus a default instance for one full pass.
module tb_mem_stream_reader;

    localparam int SLast = 7;
    localparam int BLast = 35000;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance signals
    logic        s_reset, s_start, s_ready;
    logic        s_busy, s_rd_en, s_valid, s_last, s_done;
    logic [15:0] s_addr, s_ck;
    logic [7:0]  s_rdata, s_data;

    // Default-config instance signals
    logic        b_reset, b_start, b_ready;
    logic        b_busy, b_rd_en, b_valid, b_last, b_done;
    logic [15:0] b_addr, b_ck;
    logic [7:0]  b_rdata, b_data;

    logic [7:0]  ram [0:SLast];

    mem_stream_reader #(
        .LAST_ADDR (SLast)
    ) u_small (
        .clk       (clk),
        .reset     (s_reset),
        .start     (s_start),
        .busy      (s_busy),
        .mem_rd_en (s_rd_en),
        .mem_addr  (s_addr),
        .mem_rdata (s_rdata),
        .out_data  (s_data),
        .out_valid (s_valid),
        .out_ready (s_ready),
        .out_last  (s_last),
        .done      (s_done),
        .checksum  (s_ck)
    );

    mem_stream_reader u_big (
        .clk       (clk),
        .reset     (b_reset),
        .start     (b_start),
        .busy      (b_busy),
        .mem_rd_en (b_rd_en),
        .mem_addr  (b_addr),
        .mem_rdata (b_rdata),
        .out_data  (b_data),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .out_last  (b_last),
        .done      (b_done),
        .checksum  (b_ck)
    );

    // One-cycle-latency RAMs
    always @(posedge clk) begin
        if (s_rd_en) s_rdata <= ram[s_addr[2:0]];
        if (b_rd_en) b_rdata <= b_addr[7:0];
    end

    int          checks, failures;
    int          tick_n, issued, accepted, start_tick, last_acc_tick;
    int          first_valid_tick, done_tick, done_seen;
    bit          in_pass, prev_rst;
    logic [15:0] sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model step for the small instance. Called once per cycle at
    // the falling edge after the inputs for the next rising edge are set.
    task automatic eval_small();
        bit          was_pass, exp_done;
        logic [15:0] exp_ck;
        tick_n++;
        was_pass = in_pass;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        exp_ck = sum;
`else
        exp_ck = 16'h0;
`endif
        if (prev_rst) begin
            check("rst_busy", 32'(s_busy), 32'(0));
            check("rst_rd_en", 32'(s_rd_en), 32'(0));
            check("rst_addr", 32'(s_addr), 32'(0));
            check("rst_data", 32'(s_data), 32'(0));
            check("rst_valid", 32'(s_valid), 32'(0));
            check("rst_last", 32'(s_last), 32'(0));
        end
        // done is due exactly one cycle after the final beat was accepted
        exp_done = in_pass && (last_acc_tick == tick_n - 1);
        check("done", 32'(s_done), 32'(exp_done));
        check("busy", 32'(s_busy), 32'(in_pass && tick_n > start_tick && !exp_done));
        check("checksum", 32'(s_ck), 32'(exp_ck));
        if (s_done) done_seen++;
        if (!in_pass) begin
            check("idle_valid", 32'(s_valid), 32'(0));
            check("idle_rd_en", 32'(s_rd_en), 32'(0));
        end
        if (in_pass && s_valid && first_valid_tick < 0) first_valid_tick = tick_n;
        if (s_rd_en) begin
            check("credit", 32'((issued - accepted) < 4), 32'(1));
            check("addr", 32'(s_addr), 32'(issued));
            issued++;
        end
        if (s_valid && s_ready) begin
            if (accepted <= SLast) begin
                check("data", 32'(s_data), 32'(ram[accepted]));
                check("last", 32'(s_last), 32'(accepted == SLast));
            end else begin
                check("extra_beat", 32'(accepted), 32'(SLast));
            end
            sum = sum + 16'(s_data);
            accepted++;
            if (accepted == SLast + 1) last_acc_tick = tick_n;
        end
        if (exp_done) begin
            check("done_beats", 32'(accepted), 32'(SLast + 1));
            check("done_reads", 32'(issued), 32'(SLast + 1));
            done_tick = tick_n;
            in_pass   = 1'b0;
        end
        if (s_reset) begin
            in_pass       = 1'b0;
            issued        = 0;
            accepted      = 0;
            sum           = '0;
            last_acc_tick = -100;
        end else if (s_start && !was_pass) begin
            in_pass          = 1'b1;
            issued           = 0;
            accepted         = 0;
            sum              = '0;
            start_tick       = tick_n;
            last_acc_tick    = -100;
            first_valid_tick = -1;
        end
        prev_rst = s_reset;
    endtask

    // mode 0: ready held high; 1: ready 1-on/3-off; 2: random ready at pct.
    // rst_at >= 0 pulses reset on the beat that would be accepted as that index.
    task automatic run_pass(input int mode, input int pct, input int rst_at, input bit restart);
        int d0;
        d0 = done_seen;
        @(negedge clk);
        s_start = 1'b1;
        s_reset = 1'b0;
        s_ready = (mode != 1);
        eval_small();
        for (int t = 1; t < 600 && in_pass; t++) begin
            @(negedge clk);
            case (mode)
                0:       s_ready = 1'b1;
                1:       s_ready = (t % 4 == 0);
                default: s_ready = ($urandom_range(0, 99) < pct);
            endcase
            s_start = restart && ($urandom_range(0, 5) == 0);
            s_reset = (rst_at >= 0) && (accepted == rst_at) && s_valid && s_ready;
            eval_small();
        end
        if (in_pass) begin
            check("pass_timeout", 32'(1), 32'(0));
            @(negedge clk);
            s_start = 1'b0;
            s_reset = 1'b1;
            eval_small();
        end
        @(negedge clk);
        s_start = 1'b0;
        s_reset = 1'b0;
        eval_small();
        if (rst_at < 0) check("one_done", 32'(done_seen - d0), 32'(1));
    endtask

    task automatic big_pass();
        int          iss, acc, maxa;
        bit          fin;
        logic [15:0] bsum;
        iss  = 0;
        acc  = 0;
        maxa = 0;
        fin  = 1'b0;
        bsum = '0;
        @(negedge clk);
        b_reset = 1'b0;
        b_start = 1'b1;
        for (int t = 0; t < 36500 && !fin; t++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_rd_en) begin
                check("big_addr", 32'(b_addr), 32'(iss));
                if (int'(b_addr) > maxa) maxa = int'(b_addr);
                iss++;
            end
            if (b_valid && b_ready) begin
                check("big_data", 32'(b_data), 32'(acc % 256));
                check("big_last", 32'(b_last), 32'(acc == BLast));
                bsum = bsum + 16'(b_data);
                acc++;
            end
            if (b_done) fin = 1'b1;
        end
        check("big_finished", 32'(fin), 32'(1));
        check("big_beats", 32'(acc), 32'(BLast + 1));
        check("big_reads", 32'(iss), 32'(BLast + 1));
        check("big_max_addr", 32'(maxa), 32'(BLast));
        @(negedge clk);
        check("big_addr_wrap", 32'(b_addr), 32'(0));
        check("big_idle", 32'(b_busy), 32'(0));
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        check("big_checksum", 32'(b_ck), 32'(bsum));
`else
        check("big_checksum", 32'(b_ck), 32'(0));
`endif
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        tick_n           = 0;
        issued           = 0;
        accepted         = 0;
        start_tick       = 0;
        last_acc_tick    = -100;
        first_valid_tick = -1;
        done_tick        = 0;
        done_seen        = 0;
        in_pass          = 1'b0;
        sum              = '0;
        s_reset = 1'b1;
        s_start = 1'b0;
        s_ready = 1'b0;
        b_reset = 1'b1;
        b_start = 1'b0;
        b_ready = 1'b1;
        for (int i = 0; i <= SLast; i++) ram[i] = 8'(i + 16'h10);
        repeat (3) @(negedge clk);
        prev_rst = 1'b1;

        // Directed pass: latency, throughput and final checksum
        run_pass(0, 100, -1, 1'b0);
        check("first_valid_latency", 32'(first_valid_tick - start_tick), 32'(3));
        check("done_latency", 32'(done_tick - start_tick), 32'(11));
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        // 0x10 + 0x11 + ... + 0x17
        check("checksum_final", 32'(s_ck), 32'(16'h009C));
`else
        check("checksum_final", 32'(s_ck), 32'(0));
`endif

        // Sparse consumer forces the credit limit
        run_pass(1, 0, -1, 1'b0);

        // Reset on the 5th accepted beat, then a clean pass from address 0
        run_pass(0, 100, 4, 1'b0);
        check("post_reset_idle", 32'(s_busy), 32'(0));
        run_pass(0, 100, -1, 1'b0);

        // Start re-pulsed while busy must be ignored
        run_pass(0, 100, -1, 1'b1);

        // Randomized contents and flow control
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i <= SLast; i++) ram[i] = 8'($urandom_range(0, 255));
            run_pass(2, int'($urandom_range(15, 100)), -1, 1'($urandom_range(0, 1)));
        end

        big_pass();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
